// File: rtl/sr_bank_sequencer.sv
// sr_bank_sequencer
//   Arbitrates SET/CLR/TOGGLE commands from two requesters onto a bank of N
//   clocked SR flip-flops. Drives at most one S or R line, and only for one
//   cycle per attempt. Reads Q back after a settle cycle and retries up to
//   MAX_RETRY times before reporting an error.
//
// Ports
//   CLK, RST            clock (rising edge), async active-high reset
//   REQn_VALID/READY    per-requester handshake (READY is combinational)
//   REQn_OP             00 SET, 01 CLR, 10 TOGGLE, 11 illegal
//   REQn_IDX            target flop index
//   S, R                registered set/reset lines to the bank
//   Q                   bank outputs read back
//   DONE                one-cycle completion pulse
//   DONE_ID, ERR        owner and error flag, qualified by DONE
//   BUSY                high whenever the sequencer is not idle
module sr_bank_sequencer #(
  parameter int N         = 8,
  parameter int IDX_W     = 3,
  parameter int MAX_RETRY = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [1:0]       REQ0_OP,
  input  logic [IDX_W-1:0] REQ0_IDX,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [1:0]       REQ1_OP,
  input  logic [IDX_W-1:0] REQ1_IDX,
  output logic [N-1:0]     S,
  output logic [N-1:0]     R,
  input  logic [N-1:0]     Q,
  output logic             DONE,
  output logic             DONE_ID,
  output logic             ERR,
  output logic             BUSY
);

  localparam int             RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [IDX_W:0] N_LIM     = (IDX_W+1)'(N);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DRIVE, ST_SETTLE, ST_CHECK, ST_RESP
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, id_q, exp_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RW-1:0]    retry_q, retry_d;

  logic             gnt_id, accept, req_bad, req_qbit, exp_d, err_d, done_id_d;
  logic [1:0]       req_op;
  logic [IDX_W-1:0] req_idx;
  logic [N-1:0]     set_d, clr_d;

  // Round robin: on contention the pointer decides, a lone requester always wins.
  assign gnt_id     = (REQ0_VALID && REQ1_VALID) ? ptr_q : REQ1_VALID;
  assign accept     = (state_q == ST_IDLE) && (REQ0_VALID || REQ1_VALID);
  assign REQ0_READY = accept && !gnt_id;
  assign REQ1_READY = accept &&  gnt_id;

  assign req_op   = gnt_id ? REQ1_OP  : REQ0_OP;
  assign req_idx  = gnt_id ? REQ1_IDX : REQ0_IDX;
  assign req_bad  = (req_op == 2'b11) || ({1'b0, req_idx} >= N_LIM);
  assign req_qbit = ({1'b0, req_idx} < N_LIM) ? Q[req_idx] : 1'b0;

  // Target and expected value as they will be after this edge; the lanes
  // register S/R from these so the drive appears exactly in the DRIVE cycle.
  always_comb begin
    exp_d = exp_q;
    idx_d = idx_q;
    if (accept) begin
      idx_d = req_idx;
      case (req_op)
        2'b00:   exp_d = 1'b1;
        2'b01:   exp_d = 1'b0;
        default: exp_d = ~req_qbit;  // TOGGLE: invert Q seen at accept
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    err_d     = 1'b0;
    done_id_d = id_q;
    case (state_q)
      ST_IDLE: begin
        done_id_d = gnt_id;  // illegal ops complete before id_q is visible
        if (accept) begin
          retry_d = '0;
          if (req_bad) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DRIVE:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (Q[idx_q] == exp_q) begin
          state_d = ST_RESP;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end
      end
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      exp_q   <= 1'b0;
      idx_q   <= '0;
      retry_q <= '0;
      DONE    <= 1'b0;
      DONE_ID <= 1'b0;
      ERR     <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      exp_q   <= exp_d;
      idx_q   <= idx_d;
      if (accept) begin
        id_q  <= gnt_id;
        ptr_q <= ~gnt_id;
      end
      DONE    <= (state_d == ST_RESP);
      DONE_ID <= (state_d == ST_RESP) && done_id_d;
      ERR     <= err_d;
      BUSY    <= (state_d != ST_IDLE);
    end
  end

  // Per-lane decode: one lane at most is hit, and it gets S or R, never both.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic hit;
    assign hit      = (state_d == ST_DRIVE) && (idx_d == IDX_W'(i));
    assign set_d[i] = hit &&  exp_d;
    assign clr_d[i] = hit && !exp_d;
  end

  // Async clear drops S/R in the same cycle reset is raised.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      S <= '0;
      R <= '0;
    end else begin
      S <= set_d;
      R <= clr_d;
    end
  end

endmodule

// File: tb/tb_sr_bank_sequencer.sv
// Directed bench for sr_bank_sequencer with a behavioural SR bank model
// (optional stuck-at-0 mask) driven by the DUT's S/R lines.
module tb_sr_bank_sequencer;
  localparam int N = 8;
  localparam int IDX_W = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic REQ0_READY, REQ1_READY;
  logic [1:0] REQ0_OP = 2'b00, REQ1_OP = 2'b00;
  logic [IDX_W-1:0] REQ0_IDX = '0, REQ1_IDX = '0;
  logic [N-1:0] S, R, Q;
  logic DONE, DONE_ID, ERR, BUSY;

  int checks = 0;
  int failures = 0;

  logic [N-1:0] bq = '0;
  logic [N-1:0] stuck0 = '0;
  logic [N-1:0] ld_val = '0;
  logic ld = 1'b0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ld) bq <= ld_val;
    else    bq <= (bq | S) & ~R;
  end
  assign Q = bq & ~stuck0;

  sr_bank_sequencer #(.N(N), .IDX_W(IDX_W), .MAX_RETRY(2)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OP(REQ0_OP), .REQ0_IDX(REQ0_IDX),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OP(REQ1_OP), .REQ1_IDX(REQ1_IDX),
    .S(S), .R(R), .Q(Q),
    .DONE(DONE), .DONE_ID(DONE_ID), .ERR(ERR), .BUSY(BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // S/R exclusivity on every cycle outside reset
  always @(negedge CLK) begin
    if (!RST) begin
      chk("sr_excl", 32'(S & R), 32'd0);
      chk("sr_onehot", 32'($countones(S | R) <= 1), 32'd1);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic preset(input logic [N-1:0] v);
    ld_val = v;
    ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  // Issue one command, then watch cycle by cycle from the DRIVE cycle (c=1).
  task automatic run_cmd(input string tag, input logic rid, input logic [1:0] op,
                         input logic [2:0] idx, input logic [7:0] es, input logic [7:0] er,
                         input int ep, input int elat, input logic eerr);
    int w, pulses, dlat;
    logic did, derr;
    w = 0; pulses = 0; dlat = 0; did = 1'b0; derr = 1'b0;
    if (rid) begin REQ1_OP = op; REQ1_IDX = idx; REQ1_VALID = 1'b1; end
    else     begin REQ0_OP = op; REQ0_IDX = idx; REQ0_VALID = 1'b1; end
    #1;
    while (!(rid ? REQ1_READY : REQ0_READY) && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_rdy"}, 32'(rid ? REQ1_READY : REQ0_READY), 32'd1);
    tick();
    if (rid) REQ1_VALID = 1'b0;
    else     REQ0_VALID = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if ((S | R) != '0) begin
        pulses++;
        chk({tag, "_pat"}, 32'({S, R}), 32'({es, er}));
        chk({tag, "_ppos"}, 32'((c - 1) % 3), 32'd0);
      end
      if (DONE) begin
        dlat = c; did = DONE_ID; derr = ERR;
        break;
      end
      tick();
    end
    chk({tag, "_lat"}, 32'(dlat), 32'(elat));
    chk({tag, "_pulses"}, 32'(pulses), 32'(ep));
    chk({tag, "_id"}, 32'(did), 32'(rid));
    chk({tag, "_err"}, 32'(derr), 32'(eerr));
    tick();
    chk({tag, "_idle_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_idle_done"}, 32'(DONE), 32'd0);
  endtask

  int acc_id[4], acc_t[4], done_id[4];
  int n_acc, n_done, c;
  logic drop;

  initial begin
    tick();
    tick();
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_done", 32'({DONE, DONE_ID, ERR}), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_ready", 32'({REQ0_READY, REQ1_READY}), 32'd0);
    RST = 1'b0;
    tick();

    // SET idx 3 from an all-zero bank
    run_cmd("set3", 1'b0, 2'b00, 3'd3, 8'h08, 8'h00, 1, 4, 1'b0);
    chk("set3_q", 32'(Q[3]), 32'd1);

    // Both requesters held valid: alternate 0,1,0,1 every 5 cycles
    do_reset();
    REQ0_OP = 2'b00; REQ0_IDX = 3'd0;
    REQ1_OP = 2'b01; REQ1_IDX = 3'd1;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    #1;
    n_acc = 0; n_done = 0; c = 0; drop = 1'b0;
    while ((n_acc < 4 || n_done < 4) && c < 60) begin
      if (n_acc < 4 && (REQ0_READY || REQ1_READY)) begin
        acc_id[n_acc] = int'(REQ1_READY);
        acc_t[n_acc] = c;
        n_acc++;
        if (n_acc == 4) drop = 1'b1;
      end
      if (DONE && n_done < 4) begin
        done_id[n_done] = int'(DONE_ID);
        n_done++;
      end
      tick();
      c++;
      if (drop) begin
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; drop = 1'b0;
      end
    end
    chk("rr_nacc", 32'(n_acc), 32'd4);
    chk("rr_ndone", 32'(n_done), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_gnt", 32'(acc_id[i]), 32'(i % 2));
      chk("rr_done_id", 32'(done_id[i]), 32'(i % 2));
      if (i > 0) chk("rr_gap", 32'(acc_t[i] - acc_t[i-1]), 32'd5);
    end
    tick();

    // TOGGLE idx 5 from requester 1 with Q[5]=1
    preset(8'h20);
    run_cmd("tog5", 1'b1, 2'b10, 3'd5, 8'h00, 8'h20, 1, 4, 1'b0);
    chk("tog5_q", 32'(Q[5]), 32'd0);

    // Q[2] stuck low: three S pulses, then error at A+10
    preset(8'h00);
    stuck0 = 8'h04;
    run_cmd("stuck2", 1'b0, 2'b00, 3'd2, 8'h04, 8'h00, 3, 10, 1'b1);
    stuck0 = 8'h00;

    // Illegal op: no drive, DONE in the cycle after accept
    run_cmd("ill0", 1'b0, 2'b11, 3'd0, 8'h00, 8'h00, 0, 1, 1'b1);
    run_cmd("ill7", 1'b1, 2'b11, 3'd7, 8'h00, 8'h00, 0, 1, 1'b1);

    // Reset during DRIVE of SET idx 7
    preset(8'h00);
    REQ0_OP = 2'b00; REQ0_IDX = 3'd7; REQ0_VALID = 1'b1;
    #1;
    chk("rstmid_rdy", 32'(REQ0_READY), 32'd1);
    tick();
    REQ0_VALID = 1'b0;
    chk("rstmid_drive", 32'(S), 32'h80);
    RST = 1'b1;
    #1;
    chk("rstmid_S", 32'(S), 32'd0);
    chk("rstmid_R", 32'(R), 32'd0);
    chk("rstmid_busy", 32'(BUSY), 32'd0);
    chk("rstmid_done", 32'(DONE), 32'd0);
    tick();
    tick();
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rstmid_nodone", 32'({DONE, BUSY}), 32'd0);
      tick();
    end
    chk("rstmid_q7", 32'(Q[7]), 32'd0);

    // After reset requester 0 has priority again
    REQ1_OP = 2'b01; REQ1_IDX = 3'd6; REQ1_VALID = 1'b1;
    REQ0_OP = 2'b00; REQ0_IDX = 3'd7; REQ0_VALID = 1'b1;
    #1;
    chk("rstprio", 32'({REQ0_READY, REQ1_READY}), 32'b10);
    REQ1_VALID = 1'b0;
    run_cmd("set7", 1'b0, 2'b00, 3'd7, 8'h80, 8'h00, 1, 4, 1'b0);
    chk("set7_q", 32'(Q[7]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_bank_sequencer.md
# sr_bank_sequencer

Controller that owns a bank of N clocked SR flip-flops and arbitrates SET/CLEAR/TOGGLE commands from two requesters onto it. It drives the per-flop S and R lines and guarantees that S and R are never asserted together, so the forbidden SR state cannot occur. After each write it reads back the flop's Q, retries on mismatch, and reports completion and error status. It sits between the command sources and the SR flip-flop bank, which is clocked by the same CLK.

## Interface
- N, 8, number of SR flip-flops in the bank.
- IDX_W, 3, index width; N ≤ 2^IDX_W.
- MAX_RETRY, 2, extra write attempts allowed after the first failed readback.

- CLK  in  1  Single clock, rising edge. The SR bank uses the same CLK.
- RST  in  1  Asynchronous, active-high reset.
- REQ0_VALID  in  1  Requester 0 has a command pending.
- REQ0_READY  out  1  Requester 0's command is accepted this cycle.
- REQ0_OP  in  2  Command code: 00 SET, 01 CLR, 10 TOGGLE, 11 illegal.
- REQ0_IDX  in  IDX_W  Index of the target flop.
- REQ1_VALID, REQ1_READY, REQ1_OP, REQ1_IDX  same widths as requester 0, for requester 1.
- S  out  N  Set lines to the bank.
- R  out  N  Reset lines to the bank.
- Q  in  N  Q outputs read back from the bank.
- DONE  out  1  One-cycle completion pulse.
- DONE_ID  out  1  Requester that owns the completing command.
- ERR  out  1  Qualified by DONE. High means an illegal op was given or retries were exhausted.
- BUSY  out  1  High whenever state ≠ IDLE.

## Operation
- States are IDLE, DRIVE, SETTLE, CHECK and RESP.
- IDLE handles acceptance and arbitration:
  - If any VALID is high, grant one requester round-robin.
  - The priority pointer resets to requester 0. After each grant it points to the other requester.
  - A lone requester is always granted.
  - READY is combinational: READY = (state == IDLE) and granted. It is high for exactly one cycle per accept.
- At the accept edge the block latches the op, the index, the requester ID, retry counter = 0, and the expected value:
  - SET expects 1.
  - CLR expects 0.
  - TOGGLE expects ~Q[idx], sampled at the accept edge.
- An illegal op (11) goes directly to RESP with ERR=1. No S/R activity occurs.
- An out-of-range index (idx ≥ N) is treated the same as an illegal op.
- DRIVE:
  - If expected = 1, drive S[idx]=1; otherwise drive R[idx]=1.
  - All other S/R bits are 0.
  - The flop samples S/R at the edge that ends DRIVE.
- A command is always driven, even if Q[idx] already equals the expected value.
- SETTLE: all S/R bits are 0.
- CHECK: compare Q[idx] against the expected value.
  - Match: go to RESP with ERR=0.
  - Mismatch and retry < MAX_RETRY: increment retry and go to DRIVE.
  - Mismatch and retry = MAX_RETRY: go to RESP with ERR=1.
- RESP: DONE=1 and DONE_ID/ERR are valid for one cycle, then the block returns to IDLE.
- Invariants that must hold every cycle:
  - (S & R) == 0.
  - popcount(S | R) ≤ 1.
  - S/R are nonzero only in DRIVE.
- All outputs are registered, except READY.
- Reset values: S=0, R=0, DONE=0, DONE_ID=0, ERR=0, BUSY=0, READY=0. Internally: state IDLE, pointer 0, retry 0.
- Reset asserted mid-operation:
  - S/R clear immediately, asynchronously.
  - The in-flight command is dropped; no DONE is issued for it.
  - After reset is released, arbitration restarts with requester 0 having priority.

## Timing
- Let A be the accept edge (IDLE, READY=1).
- The DRIVE cycle follows A. SETTLE is A+2, CHECK is A+3, and DONE is high during A+4.
- Each retry adds 3 cycles (DRIVE, SETTLE, CHECK). DONE occurs at A+4+3·retries.
- For an illegal op, DONE is high in the cycle after A.
- The earliest next accept is the IDLE cycle after RESP, giving a sustained rate of one command per 5 cycles.
- VALID/OP/IDX must stay stable until READY. They are not sampled after A.
- A requester may hold VALID high across its own DONE; its next command is arbitrated normally.

## Test plan
- Reset, then REQ0 SET idx 3 with bank Q=0: S[3] high for exactly one cycle at A+1, Q[3]=1, and at A+4 DONE=1, DONE_ID=0, ERR=0. A checker asserts S&R==0 on every cycle of every test.
- Both VALID held high for 4 commands: grant order is 0,1,0,1, each accept is 5 cycles apart, and DONE_ID follows the same order.
- REQ1 TOGGLE idx 5 with Q[5]=1: R[5] pulses once, Q[5]=0, DONE with ERR=0, DONE_ID=1.
- Q[2] stuck at 0, REQ0 SET idx 2, MAX_RETRY=2: three S[2] pulses spaced 3 cycles apart, then DONE at A+10 with ERR=1.
- REQ0 OP=11 idx 0: no S/R activity, DONE at A+1 with ERR=1. Repeat with idx=N (when N < 2^IDX_W): same result.
- RST asserted during DRIVE of SET idx 7: S drops to 0 within the same cycle, no DONE, BUSY=0. A later SET idx 7 completes normally, and with both requesters valid, requester 0 wins first.
